// File: rtl/dmem_resp_pkg.sv
// Shared constants for the data-memory responder: MMIO offsets, STATUS bits, default base.
package dmem_resp_pkg;

  localparam int unsigned OFS_W     = 4;
  localparam int unsigned MMIO_SPAN = 16;
  localparam int unsigned CYC_W     = 32;
  localparam int unsigned ST_W      = 2;

  localparam logic [OFS_W-1:0] OFS_CYCLE   = 4'd0;
  localparam logic [OFS_W-1:0] OFS_LED     = 4'd1;
  localparam logic [OFS_W-1:0] OFS_SCRATCH = 4'd2;
  localparam logic [OFS_W-1:0] OFS_STATUS  = 4'd3;
  localparam logic [OFS_W-1:0] OFS_TIMER   = 4'd4;

  localparam int unsigned ST_RO_ERR   = 0;
  localparam int unsigned ST_TMR_DONE = 1;

  localparam int unsigned MMIO_BASE_DEFAULT = 32'hFF0;

endpackage

// File: rtl/dmem_responder_if.sv
// Processor data-memory request/response bus.
interface dmem_responder_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  modport master (output address_dmem, data, wren, input q_dmem);
  modport slave  (input address_dmem, data, wren, output q_dmem);
endinterface

// File: rtl/dmem_mmio_regs.sv
// MMIO register block: cycle counter, LED, scratch, sticky status and countdown timer.
module dmem_mmio_regs
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sel,
  input  logic [OFS_W-1:0]  ofs,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] rdata_c,
  output logic [DATA_W-1:0] led_out,
  output logic              timer_irq
);

  logic [CYC_W-1:0]  cycle_cnt;
  logic [DATA_W-1:0] scratch;
  logic [DATA_W-1:0] timer;
  logic [ST_W-1:0]   status;

  logic            wr_cycle, wr_led, wr_scratch, wr_status, wr_timer;
  logic            tmr_expire;
  logic [ST_W-1:0] st_set, st_clr;

  // Write decode and status set/clear sources; a timer load pre-empts expiry.
  always_comb begin
    wr_cycle   = wren && sel && (ofs == OFS_CYCLE);
    wr_led     = wren && sel && (ofs == OFS_LED);
    wr_scratch = wren && sel && (ofs == OFS_SCRATCH);
    wr_status  = wren && sel && (ofs == OFS_STATUS);
    wr_timer   = wren && sel && (ofs == OFS_TIMER);
    tmr_expire = (timer == DATA_W'(1)) && !wr_timer;
    st_set              = '0;
    st_set[ST_RO_ERR]   = wr_cycle;
    st_set[ST_TMR_DONE] = tmr_expire;
    st_clr = wr_status ? data[ST_W-1:0] : '0;
  end

  // Free-running cycle counter; writes only flag ro_err.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + CYC_W'(1);
  end

  // Plain read/write registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_out <= '0;
      scratch <= '0;
    end else begin
      if (wr_led)     led_out <= data;
      if (wr_scratch) scratch <= data;
    end
  end

  // Sticky status, write-1-to-clear; a same-cycle set overrides the clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) status <= '0;
    else       status <= (status & ~st_clr) | st_set;
  end

  // Countdown timer; a load replaces the count, otherwise decrement toward 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  timer <= '0;
    else if (wr_timer)          timer <= data;
    else if (timer != '0)       timer <= timer - DATA_W'(1);
  end

  assign timer_irq = status[ST_TMR_DONE];

  // Read mux over pre-edge register values; reserved offsets read 0.
  always_comb begin
    rdata_c = '0;
    if (sel) begin
      case (ofs)
        OFS_CYCLE:   rdata_c = DATA_W'(cycle_cnt);
        OFS_LED:     rdata_c = led_out;
        OFS_SCRATCH: rdata_c = scratch;
        OFS_STATUS:  rdata_c = DATA_W'(status);
        OFS_TIMER:   rdata_c = timer;
        default:     rdata_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM below MMIO_BASE, MMIO window above, one-cycle read latency.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic [DATA_W-1:0] led_out,
  output logic              timer_irq
);

  localparam int unsigned RAM_WORDS = MMIO_BASE;

  logic [DATA_W-1:0] mem [RAM_WORDS];
  logic              ram_sel;
  logic              mmio_sel;
  logic [ADDR_W-1:0] ofs_full;
  logic [DATA_W-1:0] mmio_rdata;

  // Address decode; addresses past the 16-word window behave as reserved.
  always_comb begin
    ram_sel  = bus.address_dmem < ADDR_W'(MMIO_BASE);
    ofs_full = bus.address_dmem - ADDR_W'(MMIO_BASE);
    mmio_sel = !ram_sel && (ofs_full < ADDR_W'(MMIO_SPAN));
  end

  dmem_mmio_regs #(.DATA_W(DATA_W)) u_regs (
    .clock     (clock),
    .reset     (reset),
    .sel       (mmio_sel),
    .ofs       (ofs_full[OFS_W-1:0]),
    .data      (bus.data),
    .wren      (bus.wren),
    .rdata_c   (mmio_rdata),
    .led_out   (led_out),
    .timer_irq (timer_irq)
  );

  // RAM write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (bus.wren && ram_sel) mem[bus.address_dmem] <= bus.data;
  end

  // Read data register; samples old RAM contents on a same-address write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        bus.q_dmem <= '0;
    else if (ram_sel) bus.q_dmem <= mem[bus.address_dmem];
    else              bus.q_dmem <= mmio_rdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic vs a behavioural model.
module tb_dmem_responder;

  localparam logic [11:0] BASE = 12'hFF0;

  logic        clock;
  logic        reset;
  logic [31:0] led_out;
  logic        timer_irq;

  dmem_responder_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  dmem_responder #(.ADDR_W(12), .DATA_W(32), .MMIO_BASE(32'hFF0)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .led_out   (led_out),
    .timer_irq (timer_irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] mram [logic [11:0]];
  logic [31:0] m_cycle, m_led, m_scratch, m_timer;
  logic        m_roerr, m_tdone;
  logic [31:0] last_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cycle = 0; m_led = 0; m_scratch = 0; m_timer = 0;
    m_roerr = 1'b0; m_tdone = 1'b0;
  endtask

  // One clock edge of the memory map: compute the read result, then apply the edge's effects.
  task automatic model_step(input logic [11:0] a, input logic [31:0] d, input logic w,
                            output logic [31:0] q, output bit known);
    logic [11:0] ofs;
    bit          is_mmio;
    bit          load_tmr;
    bit          expire;
    is_mmio = (a >= BASE);
    ofs     = a - BASE;
    known   = 1'b1;
    q       = 32'h0;
    if (!is_mmio) begin
      known = mram.exists(a);
      if (known) q = mram[a];
    end else begin
      case (ofs)
        12'd0:   q = m_cycle;
        12'd1:   q = m_led;
        12'd2:   q = m_scratch;
        12'd3:   q = {30'h0, m_tdone, m_roerr};
        12'd4:   q = m_timer;
        default: q = 32'h0;
      endcase
    end
    load_tmr = w && is_mmio && (ofs == 12'd4);
    expire   = (m_timer == 32'd1) && !load_tmr;
    if (w && is_mmio && ofs == 12'd3) begin
      if (d[0]) m_roerr = 1'b0;
      if (d[1]) m_tdone = 1'b0;
    end
    if (w && is_mmio && ofs == 12'd0) m_roerr = 1'b1;
    if (expire) m_tdone = 1'b1;
    if (w && is_mmio && ofs == 12'd1) m_led = d;
    if (w && is_mmio && ofs == 12'd2) m_scratch = d;
    if (load_tmr)            m_timer = d;
    else if (m_timer != 0)   m_timer = m_timer - 1;
    m_cycle = m_cycle + 1;
    if (w && !is_mmio) mram[a] = d;
  endtask

  // Drive one request from a falling edge, check after the rising edge, return at the next falling edge.
  task automatic do_cycle(input logic [11:0] a, input logic [31:0] d, input logic w);
    logic [31:0] exp_q;
    bit          known;
    bus.address_dmem = a;
    bus.data         = d;
    bus.wren         = w;
    model_step(a, d, w, exp_q, known);
    @(posedge clock);
    #1;
    last_q = bus.q_dmem;
    if (known) check("q_dmem", bus.q_dmem, exp_q);
    check("led_out", led_out, m_led);
    check("timer_irq", 32'(timer_irq), 32'(m_tdone));
    @(negedge clock);
  endtask

  // Asynchronous reset between edges, held for two edges, released on a falling edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_q_dmem", bus.q_dmem, 32'h0);
    check("rst_led_out", led_out, 32'h0);
    check("rst_timer_irq", 32'(timer_irq), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] c0;
    reset = 1'b1;
    bus.address_dmem = '0;
    bus.data         = '0;
    bus.wren         = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // RAM write then read, and read-during-write
    do_cycle(12'h010, 32'hDEADBEEF, 1'b1);
    do_cycle(12'h010, 32'h0, 1'b0);
    check("ram_rd", last_q, 32'hDEADBEEF);
    do_cycle(12'h011, 32'd5, 1'b1);
    do_cycle(12'h011, 32'd9, 1'b1);
    check("rdw_old", last_q, 32'd5);
    do_cycle(12'h011, 32'h0, 1'b0);
    check("rdw_new", last_q, 32'd9);

    // LED and reserved space
    do_cycle(12'hFF1, 32'h0000_00A5, 1'b1);
    check("led_drive", led_out, 32'hA5);
    do_cycle(12'hFF1, 32'h0, 1'b0);
    check("led_rd", last_q, 32'hA5);
    do_cycle(12'hFF8, 32'h1234_5678, 1'b1);
    do_cycle(12'hFF8, 32'h0, 1'b0);
    check("rsvd_rd", last_q, 32'h0);

    // Timer load 3, expiry, clear, load 0
    do_cycle(12'hFF4, 32'd3, 1'b1);
    do_cycle(12'hFF4, 32'h0, 1'b0);
    check("tmr_rd0", last_q, 32'd3);
    do_cycle(12'hFF4, 32'h0, 1'b0);
    check("tmr_rd1", last_q, 32'd2);
    check("irq_early", 32'(timer_irq), 32'h0);
    do_cycle(12'hFF4, 32'h0, 1'b0);
    check("tmr_rd2", last_q, 32'd1);
    check("irq_rise", 32'(timer_irq), 32'h1);
    do_cycle(12'hFF4, 32'h0, 1'b0);
    check("tmr_rd3", last_q, 32'd0);
    do_cycle(12'hFF3, 32'h2, 1'b1);
    check("irq_clr", 32'(timer_irq), 32'h0);
    do_cycle(12'hFF4, 32'h0, 1'b1);
    do_cycle(12'hFF0, 32'h0, 1'b0);
    check("load0_no_irq", 32'(timer_irq), 32'h0);

    // Clear of tmr_done on the same edge the timer expires
    do_cycle(12'hFF4, 32'd2, 1'b1);
    do_cycle(12'hFF2, 32'd7, 1'b1);
    do_cycle(12'hFF3, 32'h2, 1'b1);
    check("clr_set_collide", 32'(timer_irq), 32'h1);

    // Write to CYCLE sets ro_err and leaves the counter running
    do_cycle(12'hFF3, 32'h3, 1'b1);
    do_cycle(12'hFF0, 32'h55, 1'b1);
    do_cycle(12'hFF3, 32'h0, 1'b0);
    check("ro_err", last_q, 32'h1);
    do_cycle(12'hFF0, 32'h0, 1'b0);
    c0 = last_q;
    do_cycle(12'hFF0, 32'h0, 1'b0);
    check("cyc_inc", last_q, c0 + 32'd1);

    // Reset mid-stream with LED, irq and a RAM read in flight
    do_cycle(12'hFF1, 32'h5A, 1'b1);
    do_cycle(12'hFF4, 32'd1, 1'b1);
    do_cycle(12'h010, 32'h0, 1'b0);
    do_reset();
    do_cycle(12'hFF0, 32'h0, 1'b0);
    check("cyc_after_rst", last_q, 32'h0);
    do_cycle(12'h010, 32'h0, 1'b0);
    check("ram_kept", last_q, 32'hDEADBEEF);

    // Counter wrap via backdoor
    dut.u_regs.cycle_cnt = 32'hFFFF_FFFE;
    m_cycle = 32'hFFFF_FFFE;
    do_cycle(12'hFF0, 32'h0, 1'b0);
    check("wrap0", last_q, 32'hFFFF_FFFE);
    do_cycle(12'hFF0, 32'h0, 1'b0);
    check("wrap1", last_q, 32'hFFFF_FFFF);
    do_cycle(12'hFF0, 32'h0, 1'b0);
    check("wrap2", last_q, 32'h0);

    // Random traffic over low RAM and the MMIO window
    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      logic        w;
      if ($urandom_range(0, 1) == 0) a = 12'($urandom_range(0, 15));
      else                           a = BASE + 12'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (a == BASE + 12'd4) d = 32'($urandom_range(0, 6));
      do_cycle(a, d, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
